// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for an RV32I load/store port.
// Byte-lane stores, sign/zero-extended loads, registered error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          go;
    logic          mem_we;
    logic          a_we;
    logic [2:0]    a_f3;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic          illegal;
    logic          misal;
    logic          oor;
    logic          err_d;
    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [31:0]   shifted;
    logic [31:0]   rdata_d;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign accept = req_valid && ready_q;
    assign rword  = mem[idx];

    // With zero wait states the access happens on the accept edge itself,
    // so the request is taken straight from the ports instead of the capture regs.
    always_comb begin
        a_we    = we_q;
        a_f3    = f3_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            a_we    = req_we;
            a_f3    = req_funct3;
            a_addr  = req_addr;
            a_wdata = req_wdata;
        end
    end

    always_comb begin
        illegal = (a_f3 == 3'b011) || (a_f3 == 3'b110) || (a_f3 == 3'b111);
        misal   = ((a_f3[1:0] == 2'b01) && a_addr[0])
               || ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
        oor     = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
        err_d   = illegal || misal || oor;
        idx     = a_addr[AW+1:2];
        shifted = rword >> {a_addr[1:0], 3'b000};
        case (a_f3)
            3'b000:  rdata_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  rdata_d = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  rdata_d = rword;
            3'b100:  rdata_d = {24'h0, shifted[7:0]};
            3'b101:  rdata_d = {16'h0, shifted[15:0]};
            default: rdata_d = 32'h0;
        endcase
        if (err_d || a_we) begin
            rdata_d = 32'h0;
        end
        case (a_f3[1:0])
            2'b00: begin
                be = 4'b0001 << a_addr[1:0];
                wd = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be = a_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{a_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = a_wdata;
            end
        endcase
    end

    always_comb begin
        go = (state_q == S_WAIT) && (cnt_q == 4'd0);
        if ((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) begin
            go = 1'b1;
        end
        mem_we = go && a_we && !err_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                            valid_q <= 1'b1;
                            rdata_q <= rdata_d;
                            err_q   <= err_d;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        rdata_q <= 32'h0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads/stores, errors, back-pressure
// and reset abort, with immediate assertions at every check point.
module tb_dmem_responder;

    localparam int W = 1;
    localparam int D = 256;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    dmem_responder #(
        .DEPTH_WORDS(D),
        .WAIT_CYCLES(W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input string tag, input logic we,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err);
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b011;
        req_addr   = ~a;
        req_wdata  = ~wd;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(W + 1));
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, " vclr"}, 32'(resp_valid), 32'd0);
        chk({tag, " rclr"}, resp_rdata, 32'h0);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        #3;
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst valid", 32'(resp_valid), 32'd0);
        chk("rst rdata", resp_rdata, 32'h0);
        chk("rst err", 32'(resp_err), 32'd0);
        #9;
        reset = 1'b1;
        #1;
        chk("ready pre-edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready first edge", 32'(req_ready), 32'd1);

        xact("SW 10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact("LW 10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        xact("LB 13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        xact("LBU 13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        xact("LH 12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        xact("LHU 10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
        xact("SB 11", 1'b1, 3'b000, 32'h11, 32'h55, 32'h0, 1'b0);
        xact("LW 10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
        xact("LW 12 mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
        xact("SH 13 mis", 1'b1, 3'b001, 32'h13, 32'h1234, 32'h0, 1'b1);
        xact("LW 10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
        xact("LW oor", 1'b0, 3'b010, 32'(4 * D), 32'h0, 32'h0, 1'b1);
        xact("f3 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        xact("SW 14", 1'b1, 3'b010, 32'h14, 32'h0, 32'h0, 1'b0);
        xact("SH 16", 1'b1, 3'b001, 32'h16, 32'hABCD1234, 32'h0, 1'b0);
        xact("LW 14", 1'b0, 3'b010, 32'h14, 32'h0, 32'h12340000, 1'b0);
        xact("LHU 16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h00001234, 1'b0);

        // back-pressure: response held, a second request waits meanwhile
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        req_funct3 = 3'b100;
        req_addr   = 32'h13;
        @(posedge clk);
        #1;
        chk("hold valid0", 32'(resp_valid), 32'd1);
        chk("hold rdata0", resp_rdata, 32'hDEAD55EF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold valid", 32'(resp_valid), 32'd1);
            chk("hold rdata", resp_rdata, 32'hDEAD55EF);
            chk("hold ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("hs valid", 32'(resp_valid), 32'd0);
        chk("hs ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("2nd accepted", 32'(req_ready), 32'd0);
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("2nd latency", 32'(n), 32'(W + 1));
        chk("2nd rdata", resp_rdata, 32'h000000DE);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;

        // reset during WAIT aborts the pending store
        xact("SW 20", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h11111111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort in wait", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort ready", 32'(req_ready), 32'd0);
        chk("abort valid", 32'(resp_valid), 32'd0);
        chk("abort rdata", resp_rdata, 32'h0);
        chk("abort err", 32'(resp_err), 32'd0);
        @(posedge clk);
        #1;
        chk("abort held", 32'(resp_valid), 32'd0);
        #2;
        reset = 1'b1;
        xact("LW 20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        xact("LW 10d", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
